dti_packer: RTL and testbench



---
 rtl/dti_packer_if.sv | 20 ++
 rtl/dti_packer.sv | 134 +++++++++++++
 tb/tb_dti_packer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dti_packer_if.sv
// ---------------------------------------------------------------------------
// dti_if : valid/ready stream bundle carrying a W-bit data word.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dti_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
  modport master   (output valid, output data, input  ready);
  modport slave    (input  valid, input  data, output ready);
endinterface

`default_nettype wire

// File: rtl/dti_packer.sv
// ---------------------------------------------------------------------------
// dti_packer : packs RATIO narrow dti words into one wide word {last,count,lanes}.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dti_packer #(
  parameter int DIN      = 16,
  parameter int RATIO    = 4,
  parameter int FLUSH_EN = 1
) (
  input  logic     clk,
  input  logic     rst,
  dti_if.consumer  din,
  dti_if.producer  dout
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LW = RATIO * DIN;
  localparam int OW = LW + CW + 1;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [LW-1:0] buf_q,   buf_d;
  logic          last_q,  last_d;
  logic          ovalid_q, ovalid_d;
  logic [OW-1:0] odata_q,  odata_d;

  logic          out_free;
  logic [DIN-1:0] in_word;
  logic          in_last;
  logic          accept;
  logic          complete;
  logic [LW-1:0] buf_wr;
  logic          last_wr;
  logic          load;
  logic [LW-1:0] load_buf;
  logic          load_last;

  assign din.ready  = (state_q == S_FILL);
  assign dout.valid = ovalid_q;
  assign dout.data  = odata_q;

  always_comb begin
    out_free = !ovalid_q || dout.ready;
    in_word  = din.data[DIN-1:0];
    in_last  = din.data[DIN];
    accept   = (state_q == S_FILL) && din.valid;

    buf_wr = buf_q;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IW'(i)) buf_wr[i*DIN +: DIN] = in_word;
    end
    last_wr  = last_q | in_last;
    complete = accept && ((idx_q == IW'(RATIO - 1)) || ((FLUSH_EN != 0) && in_last));

    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    last_d    = last_q;
    ovalid_d  = ovalid_q && !dout.ready;
    odata_d   = odata_q;
    load      = 1'b0;
    load_buf  = buf_q;
    load_last = last_q;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (complete) begin
            if (out_free) begin
              load      = 1'b1;
              load_buf  = buf_wr;
              load_last = last_wr;
              idx_d     = '0;
              buf_d     = '0;
              last_d    = 1'b0;
            end else begin
              // idx stays on the final lane so the pending count is idx+1
              buf_d   = buf_wr;
              last_d  = last_wr;
              state_d = S_PEND;
            end
          end else begin
            buf_d  = buf_wr;
            last_d = last_wr;
            idx_d  = idx_q + IW'(1);
          end
        end
      end
      S_PEND: begin
        if (out_free) begin
          load    = 1'b1;
          idx_d   = '0;
          buf_d   = '0;
          last_d  = 1'b0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    // Unused lanes are already zero because the buffer is cleared after each pack.
    if (load) begin
      ovalid_d = 1'b1;
      odata_d  = {load_last, CW'(idx_q) + CW'(1), load_buf};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FILL;
      idx_q    <= '0;
      buf_q    <= '0;
      last_q   <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      last_q   <= last_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dti_packer.sv
// Scoreboard bench: three packers (RATIO=4 flush, RATIO=1, RATIO=4 no-flush) share clk/rst.
`default_nettype none

module tb_dti_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid [3];
  logic [15:0] in_word  [3];
  logic        in_last  [3];
  logic        dout_ready [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic [67:0] out_data [3];

  dti_if #(.W(17)) a_in ();
  dti_if #(.W(68)) a_out ();
  dti_if #(.W(17)) b_in ();
  dti_if #(.W(18)) b_out ();
  dti_if #(.W(17)) c_in ();
  dti_if #(.W(68)) c_out ();

  assign a_in.valid  = in_valid[0];
  assign a_in.data   = {in_last[0], in_word[0]};
  assign a_out.ready = dout_ready[0];
  assign b_in.valid  = in_valid[1];
  assign b_in.data   = {in_last[1], in_word[1]};
  assign b_out.ready = dout_ready[1];
  assign c_in.valid  = in_valid[2];
  assign c_in.data   = {in_last[2], in_word[2]};
  assign c_out.ready = dout_ready[2];

  assign in_ready[0]  = a_in.ready;
  assign in_ready[1]  = b_in.ready;
  assign in_ready[2]  = c_in.ready;
  assign out_valid[0] = a_out.valid;
  assign out_valid[1] = b_out.valid;
  assign out_valid[2] = c_out.valid;
  assign out_data[0]  = a_out.data;
  assign out_data[1]  = {50'b0, b_out.data};
  assign out_data[2]  = c_out.data;

  dti_packer #(.DIN(16), .RATIO(4), .FLUSH_EN(1)) u_a (.clk(clk), .rst(rst), .din(a_in), .dout(a_out));
  dti_packer #(.DIN(16), .RATIO(1), .FLUSH_EN(1)) u_b (.clk(clk), .rst(rst), .din(b_in), .dout(b_out));
  dti_packer #(.DIN(16), .RATIO(4), .FLUSH_EN(0)) u_c (.clk(clk), .rst(rst), .din(c_in), .dout(c_out));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per-DUT assembly state and expected-output queues.
  int          m_ratio [3] = '{4, 1, 4};
  int          m_cw    [3] = '{3, 1, 3};
  bit          m_flush [3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] m_lane  [3][4];
  int          m_idx   [3];
  logic        m_last  [3];
  logic [67:0] q0 [$];
  logic [67:0] q1 [$];
  logic [67:0] q2 [$];
  int          n_out [3];

  task automatic model_clear(input int k);
    for (int i = 0; i < 4; i++) m_lane[k][i] = '0;
    m_idx[k]  = 0;
    m_last[k] = 1'b0;
  endtask

  task automatic push_exp(input int k, input logic [67:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_accept(input int k, input logic [15:0] w, input logic l);
    logic [67:0] e;
    logic [3:0]  cnt;
    m_lane[k][m_idx[k]] = w;
    m_last[k] = m_last[k] | l;
    if (m_idx[k] == m_ratio[k] - 1 || (m_flush[k] && l)) begin
      e   = '0;
      cnt = 4'(m_idx[k] + 1);
      for (int i = 0; i < m_ratio[k]; i++) e[i*16 +: 16] = m_lane[k][i];
      for (int b = 0; b < m_cw[k]; b++) e[m_ratio[k]*16 + b] = cnt[b];
      e[m_ratio[k]*16 + m_cw[k]] = m_last[k];
      push_exp(k, e);
      model_clear(k);
    end else begin
      m_idx[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && dout_ready[k]) begin
          logic [67:0] e;
          int sz;
          sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
          if (sz == 0) begin
            chk($sformatf("dut%0d_unexpected_out", k), out_data[k], 68'h0);
            chk($sformatf("dut%0d_queue_empty", k), 68'(sz), 68'd1);
          end else begin
            e = (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
            chk($sformatf("dut%0d_pack", k), out_data[k], e);
            n_out[k]++;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int k, input logic [15:0] w, input logic l);
    bit acc = 1'b0;
    int n   = 0;
    in_valid[k] = 1'b1;
    in_word[k]  = w;
    in_last[k]  = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready[k]) acc = 1'b1; else n++;
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
    if (acc) model_accept(k, w, l);
    else chk($sformatf("dut%0d_accept_timeout", k), 68'd0, 68'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queues_empty", 68'(q0.size() + q1.size() + q2.size()), 68'd0);
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_valid", 68'(out_valid[0]), 68'd0);
    for (int k = 0; k < 3; k++) model_clear(k);
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_dout_valid", 68'(out_valid[0]), 68'd0);
    chk("post_rst_din_ready", 68'(in_ready[0]), 68'd1);
  endtask

  initial begin
    int t0;
    logic [67:0] snap;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_word[k] = '0; in_last[k] = 1'b0;
      dout_ready[k] = 1'b1; n_out[k] = 0;
      model_clear(k);
    end

    // Reset values
    #12;
    chk("reset_dout_valid", 68'(out_valid[0]), 68'd0);
    chk("reset_dout_data", out_data[0], 68'd0);
    chk("reset_din_ready", 68'(in_ready[0]), 68'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    idle(2);

    // Full pack, back to back; valid one cycle after the fourth accept
    send(0, 16'h1111, 1'b0);
    send(0, 16'h2222, 1'b0);
    send(0, 16'h3333, 1'b0);
    chk("no_early_valid", 68'(out_valid[0]), 68'd0);
    send(0, 16'h4444, 1'b0);
    chk("latency_valid", 68'(out_valid[0]), 68'd1);
    chk("full_pack_word", out_data[0], {1'b0, 3'd4, 64'h4444_3333_2222_1111});
    wait_drain();

    // Flush on last, then the next pack starts at lane 0
    send(0, 16'hAAAA, 1'b0);
    send(0, 16'hBBBB, 1'b1);
    chk("flush_word", out_data[0], {1'b1, 3'd2, 64'h0000_0000_BBBB_AAAA});
    send(0, 16'hC001, 1'b0);
    send(0, 16'hC002, 1'b0);
    send(0, 16'hC003, 1'b0);
    send(0, 16'hC004, 1'b1);
    wait_drain();

    // Backpressure: second pack parks in PEND
    dout_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 16'(16'h5000 + i), 1'b0);
    chk("bp_din_ready_pend", 68'(in_ready[0]), 68'd0);
    chk("bp_dout_valid", 68'(out_valid[0]), 68'd1);
    snap = out_data[0];
    idle(5);
    chk("bp_data_stable", out_data[0], snap);
    chk("bp_first_pack", out_data[0], q0[0]);
    dout_ready[0] = 1'b1;
    wait_drain();
    chk("bp_din_ready_back", 68'(in_ready[0]), 68'd1);

    // RATIO=1: 100 random words at one per cycle
    t0 = cyc;
    for (int i = 0; i < 100; i++) send(1, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    chk("r1_throughput_cycles", 68'(cyc - t0), 68'd100);
    wait_drain();
    chk("r1_output_count", 68'(n_out[1]), 68'd100);

    // Reset mid-pack (idx=2)
    send(0, 16'hDEAD, 1'b0);
    send(0, 16'hBEEF, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) send(0, 16'(16'h7100 + i), 1'b0);
    wait_drain();

    // Reset while in PEND
    dout_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 16'(16'h6000 + i), 1'b0);
    chk("pend_before_rst", 68'(in_ready[0]), 68'd0);
    pulse_reset();
    dout_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 16'(16'h7200 + i), 1'b0);
    wait_drain();

    // FLUSH_EN=0: last on word 2 does not end the pack
    send(2, 16'h0A01, 1'b0);
    send(2, 16'h0A02, 1'b1);
    send(2, 16'h0A03, 1'b0);
    chk("noflush_no_early_out", 68'(out_valid[2]), 68'd0);
    send(2, 16'h0A04, 1'b0);
    chk("noflush_word", out_data[2], {1'b1, 3'd4, 64'h0A04_0A03_0A02_0A01});
    wait_drain();

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
